// File: rtl/prio_enc_pkg.sv
// Shared sizes, output state encoding and mask helper for the 4-to-2 priority encoder.
package prio_enc_pkg;

    localparam int N = 4;
    localparam int W = $clog2(N);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        logic [N-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational search: first set bit of mask scanning upward from start, wrapping modulo N.
module prio_pick
    import prio_enc_pkg::*;
(
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] j;

    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            // W-bit addition wraps naturally because N is a power of two
            j = start + k[W-1:0];
            if (!any && mask[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_encoder4to2_seq.sv
// Registered 4-to-2 priority encoder: D latched into pend, one code per V&R transfer, Y/V held under R=0.
// Code appears one edge after capture; PRIO_ENC_ROUND_ROBIN_EN selects rotating instead of highest-first priority.
module prio_encoder4to2_seq
    import prio_enc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         E,
    input  logic [N-1:0] D,
    input  logic         R,
    output logic [W-1:0] Y,
    output logic         V,
    output logic [N-1:0] pend,
    output logic         err
);

    state_t       state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic [N-1:0] pend_q, pend_d;
    logic         err_q, err_d;

    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         slot_free;
    logic         load;
    logic [N-1:0] clr;
    logic [N-1:0] set;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    prio_pick u_pick (
        .mask  (pend_q),
        .start (ptr_q),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic [N-1:0] mask_rev;
    logic [W-1:0] idx_rev;

    // Highest-first search is an ascending search over the bit-reversed mask
    always_comb begin
        for (int i = 0; i < N; i++) begin
            mask_rev[i] = pend_q[N-1-i];
        end
    end

    prio_pick u_pick (
        .mask  (mask_rev),
        .start ('0),
        .idx   (idx_rev),
        .any   (pick_any)
    );

    assign pick_idx = W'(N-1) - idx_rev;
`endif

    assign slot_free = (state_q == EMPTY) || (V && R);
    assign load      = slot_free && pick_any;
    assign clr       = load ? onehot(pick_idx) : '0;
    assign set       = E ? D : '0;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        pend_d  = (pend_q & ~clr) | set;
        // A set landing on a bit being cleared this edge is a fresh request, not a coalesce
        err_d   = err_q | (|(set & pend_q & ~clr));
        if (load) begin
            y_d = pick_idx;
        end
        case (state_q)
            EMPTY: if (pick_any) state_d = FULL;
            FULL:  if (R)        state_d = pick_any ? FULL : EMPTY;
            default:             state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            y_q     <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign Y    = y_q;
    assign V    = (state_q == FULL);
    assign pend = pend_q;
    assign err  = err_q;

endmodule

// File: tb/tb_prio_encoder4to2_seq.sv
// Directed bench for prio_encoder4to2_seq (default fixed-priority build).
module tb_prio_encoder4to2_seq;

    logic       clk;
    logic       rst_n;
    logic       E;
    logic [3:0] D;
    logic       R;
    logic [1:0] Y;
    logic       V;
    logic [3:0] pend;
    logic       err;

    int total;
    int bad;

    prio_encoder4to2_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .E     (E),
        .D     (D),
        .R     (R),
        .Y     (Y),
        .V     (V),
        .pend  (pend),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed vector layout: {V, Y[1:0], pend[3:0], err}
    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0; E = 1'b0; D = 4'b0000; R = 1'b0;
        #3;
        exp = {1'b0, 2'd0, 4'b0000, 1'b0};
        total++;
        if ({V, Y, pend, err} !== exp) begin
            bad++;
            $display("FAIL reset: got %b want %b", {V, Y, pend, err}, exp);
        end
        tick();
        #2 rst_n = 1'b1;
        D = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({V, Y, pend, err} !== exp) begin
                bad++;
                $display("FAIL e_low_ignore[%0d]: got %b want %b", i, {V, Y, pend, err}, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] exp [3];
        exp[0] = {1'b0, 2'd0, 4'b0100, 1'b0};
        exp[1] = {1'b1, 2'd2, 4'b0000, 1'b0};
        exp[2] = {1'b0, 2'd2, 4'b0000, 1'b0};
        R = 1'b1; E = 1'b1; D = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            E = 1'b0;
            total++;
            if ({V, Y, pend, err} !== exp[i]) begin
                bad++;
                $display("FAIL single[%0d]: got %b want %b", i, {V, Y, pend, err}, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [5];
        exp[0] = {1'b0, 2'd2, 4'b1011, 1'b0};
        exp[1] = {1'b1, 2'd3, 4'b0011, 1'b0};
        exp[2] = {1'b1, 2'd1, 4'b0001, 1'b0};
        exp[3] = {1'b1, 2'd0, 4'b0000, 1'b0};
        exp[4] = {1'b0, 2'd0, 4'b0000, 1'b0};
        R = 1'b1; E = 1'b1; D = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            E = 1'b0;
            total++;
            if ({V, Y, pend, err} !== exp[i]) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, {V, Y, pend, err}, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp;
        R = 1'b0; E = 1'b1; D = 4'b1001;
        tick();
        E = 1'b0;
        exp = {1'b0, 2'd0, 4'b1001, 1'b0};
        total++;
        if ({V, Y, pend, err} !== exp) begin
            bad++;
            $display("FAIL bp_capture: got %b want %b", {V, Y, pend, err}, exp);
        end
        exp = {1'b1, 2'd3, 4'b0001, 1'b0};
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if ({V, Y, pend, err} !== exp) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got %b want %b", i, {V, Y, pend, err}, exp);
            end
        end
        R = 1'b1;
        tick();
        exp = {1'b1, 2'd0, 4'b0000, 1'b0};
        total++;
        if ({V, Y, pend, err} !== exp) begin
            bad++;
            $display("FAIL bp_release: got %b want %b", {V, Y, pend, err}, exp);
        end
        tick();
        exp = {1'b0, 2'd0, 4'b0000, 1'b0};
        total++;
        if ({V, Y, pend, err} !== exp) begin
            bad++;
            $display("FAIL bp_drain: got %b want %b", {V, Y, pend, err}, exp);
        end
    endtask

    task automatic test_coalesce();
        logic [7:0] exp [5];
        logic [3:0] din [5];
        logic       en  [5];
        exp[0] = {1'b0, 2'd0, 4'b1000, 1'b0}; din[0] = 4'b1000; en[0] = 1'b1;
        exp[1] = {1'b1, 2'd3, 4'b0000, 1'b0}; din[1] = 4'b0000; en[1] = 1'b0;
        exp[2] = {1'b1, 2'd3, 4'b0010, 1'b0}; din[2] = 4'b0010; en[2] = 1'b1;
        exp[3] = {1'b1, 2'd3, 4'b0010, 1'b1}; din[3] = 4'b0010; en[3] = 1'b1;
        exp[4] = {1'b1, 2'd3, 4'b0010, 1'b1}; din[4] = 4'b0010; en[4] = 1'b0;
        R = 1'b0;
        for (int i = 0; i < 5; i++) begin
            E = en[i]; D = din[i];
            tick();
            total++;
            if ({V, Y, pend, err} !== exp[i]) begin
                bad++;
                $display("FAIL coalesce[%0d]: got %b want %b", i, {V, Y, pend, err}, exp[i]);
            end
        end
        E = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] exp;
        E = 1'b1; D = 4'b0100; R = 1'b0;
        tick();
        E = 1'b0;
        exp = {1'b1, 2'd3, 4'b0110, 1'b1};
        total++;
        if ({V, Y, pend, err} !== exp) begin
            bad++;
            $display("FAIL pre_reset: got %b want %b", {V, Y, pend, err}, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        exp = {1'b0, 2'd0, 4'b0000, 1'b0};
        total++;
        if ({V, Y, pend, err} !== exp) begin
            bad++;
            $display("FAIL async_reset: got %b want %b", {V, Y, pend, err}, exp);
        end
        R = 1'b1;
        tick();
        total++;
        if ({V, Y, pend, err} !== exp) begin
            bad++;
            $display("FAIL reset_held: got %b want %b", {V, Y, pend, err}, exp);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_set_clear();
        logic [7:0] exp [4];
        exp[0] = {1'b0, 2'd0, 4'b0100, 1'b0};
        exp[1] = {1'b1, 2'd2, 4'b0100, 1'b0};
        exp[2] = {1'b1, 2'd2, 4'b0000, 1'b0};
        exp[3] = {1'b0, 2'd2, 4'b0000, 1'b0};
        R = 1'b1; E = 1'b1; D = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) E = 1'b0;
            total++;
            if ({V, Y, pend, err} !== exp[i]) begin
                bad++;
                $display("FAIL set_clear[%0d]: got %b want %b", i, {V, Y, pend, err}, exp[i]);
            end
        end
    endtask

    task automatic test_same_index();
        logic [7:0] exp [5];
        logic [3:0] din [5];
        logic       en  [5];
        logic       rdy [5];
        exp[0] = {1'b0, 2'd2, 4'b1000, 1'b0}; din[0] = 4'b1000; en[0] = 1'b1; rdy[0] = 1'b0;
        exp[1] = {1'b1, 2'd3, 4'b0000, 1'b0}; din[1] = 4'b0000; en[1] = 1'b0; rdy[1] = 1'b0;
        exp[2] = {1'b1, 2'd3, 4'b1000, 1'b0}; din[2] = 4'b1000; en[2] = 1'b1; rdy[2] = 1'b0;
        exp[3] = {1'b1, 2'd3, 4'b0000, 1'b0}; din[3] = 4'b0000; en[3] = 1'b0; rdy[3] = 1'b1;
        exp[4] = {1'b0, 2'd3, 4'b0000, 1'b0}; din[4] = 4'b0000; en[4] = 1'b0; rdy[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            E = en[i]; D = din[i]; R = rdy[i];
            tick();
            total++;
            if ({V, Y, pend, err} !== exp[i]) begin
                bad++;
                $display("FAIL same_index[%0d]: got %b want %b", i, {V, Y, pend, err}, exp[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_coalesce();
        test_async_reset();
        test_set_clear();
        test_same_index();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
